// File: rtl/dram_pkg.sv
// Shared DRAM protocol definitions: command/state/error encodings and timing constants.
package dram_pkg;
    localparam int tRCD   = 3;
    localparam int tRAS   = 8;
    localparam int tRP    = 3;
    localparam int tRFC   = 12;
    localparam int tRL    = 4;
    localparam int tWL    = 2;
    localparam int tBURST = 4;
    localparam int tWR    = 3;

    localparam int TIMER_W = 10;

    typedef enum logic [2:0] {
        NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4, REF = 3'd5
    } dram_cmd_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0, ACTIVATING = 3'd1, ACTIVE = 3'd2, PRECHARGING = 3'd3, REFRESHING = 3'd4
    } bank_state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0, ERR_STATE = 2'd1, ERR_TIMING = 2'd2, ERR_BUSY = 2'd3
    } err_code_t;

    typedef struct packed {
        logic               active;
        logic               is_wr;
        logic [TIMER_W-1:0] cyc;    // cycles since the RD/WR was accepted
    } burst_t;

    // States that only leave on their own timer and refuse every command
    function automatic logic is_timed(bank_state_t s);
        return (s == ACTIVATING) || (s == PRECHARGING) || (s == REFRESHING);
    endfunction
endpackage

// File: rtl/dram_cmd_responder_if.sv
// Controller <-> DRAM responder command/data bus.
interface dram_cmd_responder_if #(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic [2:0]        cmd;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic [2:0]        bank_state;
    logic [ROW_W-1:0]  open_row;
    logic              err;
    logic [1:0]        err_code;
    logic              err_sticky;

    modport master (
        output cmd_valid, cmd, row, col, wdata,
        input  rdata, rdata_valid, bank_state, open_row, err, err_code, err_sticky
    );
    modport slave (
        input  cmd_valid, cmd, row, col, wdata,
        output rdata, rdata_valid, bank_state, open_row, err, err_code, err_sticky
    );
endinterface

// File: rtl/dram_resp_storage.sv
// Word array behind the responder: synchronous write, combinational read, no reset.
module dram_resp_storage #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/dram_cmd_responder.sv
// Single-bank DRAM device model: bank FSM, timing checks, read/write burst sequencing.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int DATA_W = 32
) (
    input logic CLK,
    input logic nRST,
    dram_cmd_responder_if.slave bus
);
    localparam int AW      = ROW_W + COL_W;
    localparam int RD_LAST = tRL + tBURST - 1;
    localparam int WR_LAST = tWL + tBURST - 1;

    bank_state_t        state;
    logic [TIMER_W-1:0] tmr, ras_cnt, wr_cnt;
    burst_t             bst;
    logic [COL_W-1:0]   bcol;
    logic [ROW_W-1:0]   row_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               rvld_q, err_q, sticky_q;
    err_code_t          code_q, code;
    logic               acc, go;

    always_comb begin
        acc  = bus.cmd_valid && (bus.cmd != 3'(NOP));
        code = ERR_NONE;
        if (!acc)
            code = ERR_NONE;
        else if (bst.active && (bus.cmd == 3'(RD) || bus.cmd == 3'(WR) || bus.cmd == 3'(PRE)))
            code = ERR_BUSY;
        else if (is_timed(state))
            code = ERR_TIMING;
        else if (state == ACTIVE && bus.cmd == 3'(PRE) && (ras_cnt != '0 || wr_cnt != '0))
            code = ERR_TIMING;
        else if (bus.cmd > 3'(REF))
            code = ERR_STATE;
        else if (state == IDLE && (bus.cmd == 3'(RD) || bus.cmd == 3'(WR) || bus.cmd == 3'(PRE)))
            code = ERR_STATE;
        else if (state == ACTIVE && (bus.cmd == 3'(ACT) || bus.cmd == 3'(REF)))
            code = ERR_STATE;
        go = acc && (code == ERR_NONE);
    end

    // Read beats are fetched one cycle ahead so rdata can be registered
    logic [TIMER_W-1:0] rd_beat, wr_beat;
    logic               rd_fetch, wr_en, burst_last;
    logic [AW-1:0]      raddr, waddr;
    logic [DATA_W-1:0]  rd_word;

    assign rd_beat    = bst.cyc - TIMER_W'(tRL - 1);
    assign wr_beat    = bst.cyc - TIMER_W'(tWL);
    assign rd_fetch   = bst.active && !bst.is_wr &&
                        bst.cyc >= TIMER_W'(tRL - 1) && bst.cyc <= TIMER_W'(RD_LAST - 1);
    assign wr_en      = bst.active && bst.is_wr &&
                        bst.cyc >= TIMER_W'(tWL) && bst.cyc <= TIMER_W'(WR_LAST);
    assign burst_last = bst.active &&
                        bst.cyc == (bst.is_wr ? TIMER_W'(WR_LAST) : TIMER_W'(RD_LAST));
    assign raddr      = {row_q, bcol + COL_W'(rd_beat)};
    assign waddr      = {row_q, bcol + COL_W'(wr_beat)};

    dram_resp_storage #(.AW(AW), .DW(DATA_W)) u_storage (
        .CLK   (CLK),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (bus.wdata),
        .raddr (raddr),
        .rdata (rd_word)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            tmr      <= '0;
            ras_cnt  <= '0;
            wr_cnt   <= '0;
            bst      <= '0;
            bcol     <= '0;
            row_q    <= '0;
            rdata_q  <= '0;
            rvld_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
            sticky_q <= 1'b0;
        end else begin
            err_q   <= (code != ERR_NONE);
            code_q  <= code;
            if (code != ERR_NONE) sticky_q <= 1'b1;
            rvld_q  <= rd_fetch;
            rdata_q <= rd_fetch ? rd_word : '0;

            if (ras_cnt != '0) ras_cnt <= ras_cnt - 1'b1;
            if (wr_cnt != '0)  wr_cnt  <= wr_cnt - 1'b1;

            if (bst.active) begin
                bst.cyc <= bst.cyc + 1'b1;
                if (burst_last) begin
                    bst.active <= 1'b0;
                    // tWR counts from the cycle after the last write beat
                    if (bst.is_wr) wr_cnt <= TIMER_W'(tWR);
                end
            end

            case (state)
                IDLE: begin
                    if (go && bus.cmd == 3'(ACT)) begin
                        state   <= ACTIVATING;
                        tmr     <= TIMER_W'(tRCD - 1);
                        ras_cnt <= TIMER_W'(tRAS - 1);
                        row_q   <= bus.row;
                    end else if (go && bus.cmd == 3'(REF)) begin
                        state <= REFRESHING;
                        tmr   <= TIMER_W'(tRFC - 1);
                    end
                end
                ACTIVATING, PRECHARGING, REFRESHING: begin
                    tmr <= tmr - 1'b1;
                    if (tmr == TIMER_W'(1))
                        state <= (state == ACTIVATING) ? ACTIVE : IDLE;
                end
                ACTIVE: begin
                    if (go && bus.cmd == 3'(PRE)) begin
                        state <= PRECHARGING;
                        tmr   <= TIMER_W'(tRP - 1);
                        row_q <= '0;
                    end else if (go) begin
                        bst.active <= 1'b1;
                        bst.is_wr  <= (bus.cmd == 3'(WR));
                        bst.cyc    <= TIMER_W'(1);
                        bcol       <= bus.col;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvld_q;
    assign bus.bank_state  = state;
    assign bus.open_row    = row_q;
    assign bus.err         = err_q;
    assign bus.err_code    = code_q;
    assign bus.err_sticky  = sticky_q;
endmodule
